// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a fixed-latency path
// and a handshaked divider path guarded by a timeout.
module alu_arbiter #(
    parameter int unsigned                DATA_WIDTH     = 8,
    parameter int unsigned                INSTR_WIDTH    = 5,
    parameter logic [INSTR_WIDTH-1:0]     CODE_INSTR_NOP = 5'b00000,
    parameter logic [INSTR_WIDTH-1:0]     CODE_INSTR_DIV = 5'b00100,
    parameter int unsigned                FIXED_LATENCY  = 2,
    parameter int unsigned                DIV_TIMEOUT    = 64
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic                   Req0Valid,
    output logic                   Req0Ready,
    input  logic [INSTR_WIDTH-1:0] Req0Instruction,
    input  logic [DATA_WIDTH-1:0]  Req0InputA,
    input  logic [DATA_WIDTH-1:0]  Req0InputB,
    input  logic                   Req1Valid,
    output logic                   Req1Ready,
    input  logic [INSTR_WIDTH-1:0] Req1Instruction,
    input  logic [DATA_WIDTH-1:0]  Req1InputA,
    input  logic [DATA_WIDTH-1:0]  Req1InputB,
    output logic [INSTR_WIDTH-1:0] AluInstruction,
    output logic [DATA_WIDTH-1:0]  AluInputA,
    output logic [DATA_WIDTH-1:0]  AluInputB,
    input  logic [DATA_WIDTH-1:0]  AluResultA,
    input  logic [DATA_WIDTH-1:0]  AluResultB,
    input  logic                   AluReady,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic                   RspId,
    output logic [DATA_WIDTH-1:0]  RspResultA,
    output logic [DATA_WIDTH-1:0]  RspResultB,
    output logic                   RspError,
    output logic                   Busy
);

    localparam int unsigned MAX_CYCLES = (FIXED_LATENCY > DIV_TIMEOUT) ? FIXED_LATENCY : DIV_TIMEOUT;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] FIXED_CNT = CNT_W'(FIXED_LATENCY);
    localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   id_q, id_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0]  res_a_q, res_a_d, res_b_q, res_b_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   grant0, grant1, accept, is_div;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            instr_q      <= CODE_INSTR_NOP;
            a_q          <= '0;
            b_q          <= '0;
            res_a_q      <= '0;
            res_b_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            instr_q      <= instr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_a_q      <= res_a_d;
            res_b_q      <= res_b_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Grant is gated by ResetN so no Ready can leak out while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (ResetN && state_q == S_IDLE) begin
            if (Req0Valid && Req1Valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = Req0Valid;
                grant1 = Req1Valid;
            end
        end
    end

    assign accept = grant0 || grant1;
    assign is_div = (instr_q == CODE_INSTR_DIV);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        instr_d      = instr_q;
        a_d          = a_q;
        b_d          = b_q;
        res_a_d      = res_a_q;
        res_b_d      = res_b_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_EXEC;
                    last_grant_d = grant1;
                    id_d         = grant1;
                    instr_d      = grant1 ? Req1Instruction : Req0Instruction;
                    a_d          = grant1 ? Req1InputA : Req0InputA;
                    b_d          = grant1 ? Req1InputB : Req0InputB;
                    cnt_d        = ONE_CNT;
                end
            end
            S_EXEC: begin
                // cnt_q holds the 1-based index of the current EXEC cycle.
                if (is_div) begin
                    if (cnt_q > ONE_CNT && AluReady) begin
                        state_d = S_RESP;
                        res_a_d = AluResultA;
                        res_b_d = AluResultB;
                        err_d   = 1'b0;
                    end else if (cnt_q >= DIV_CNT) begin
                        state_d = S_RESP;
                        res_a_d = '0;
                        res_b_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end else if (cnt_q >= FIXED_CNT) begin
                    state_d = S_RESP;
                    res_a_d = AluResultA;
                    res_b_d = AluResultB;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            S_RESP: begin
                if (RspReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Req0Ready      = grant0;
        Req1Ready      = grant1;
        Busy           = (state_q != S_IDLE);
        AluInstruction = Busy ? instr_q : CODE_INSTR_NOP;
        AluInputA      = Busy ? a_q : '0;
        AluInputB      = Busy ? b_q : '0;
        RspValid       = (state_q == S_RESP);
        RspId          = RspValid && id_q;
        RspResultA     = RspValid ? res_a_q : '0;
        RspResultB     = RspValid ? res_b_q : '0;
        RspError       = RspValid && err_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU/divider
// environment and a latency/arbitration reference model.
module tb_alu_arbiter;

    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] DIV = 5'b00100;
    localparam int FIXED = 2;
    localparam int TMO   = 64;

    typedef struct {
        logic [4:0] instr;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    typedef struct {
        int         granted;
        int         lat;
        logic       id;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       err;
        int         alu_bad;
        int         grant_bad;
        int         rsp_unstable;
        logic       after_busy;
        logic       after_valid;
        int         idle_alu_bad;
        int         timed_out;
    } obs_t;

    logic       Clk, ResetN;
    logic       Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [4:0] Req0Instruction, Req1Instruction, AluInstruction;
    logic [7:0] Req0InputA, Req0InputB, Req1InputA, Req1InputB;
    logic [7:0] AluInputA, AluInputB, AluResultA, AluResultB;
    logic       AluReady, RspValid, RspReady, RspId, RspError, Busy;
    logic [7:0] RspResultA, RspResultB;

    int n_tests = 0;
    int n_fail  = 0;
    logic model_last = 1'b1;

    // divider environment
    int unsigned div_cnt;
    int unsigned div_dly = 0;
    logic        div_rdy_en = 1'b1;
    logic        ready_noise = 1'b0;

    alu_arbiter #(
        .DATA_WIDTH(8), .INSTR_WIDTH(5), .CODE_INSTR_NOP(5'b00000), .CODE_INSTR_DIV(5'b00100),
        .FIXED_LATENCY(2), .DIV_TIMEOUT(64)
    ) dut (
        .Clk(Clk), .ResetN(ResetN),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Instruction(Req0Instruction),
        .Req0InputA(Req0InputA), .Req0InputB(Req0InputB),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Instruction(Req1Instruction),
        .Req1InputA(Req1InputA), .Req1InputB(Req1InputB),
        .AluInstruction(AluInstruction), .AluInputA(AluInputA), .AluInputB(AluInputB),
        .AluResultA(AluResultA), .AluResultB(AluResultB), .AluReady(AluReady),
        .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
        .RspResultA(RspResultA), .RspResultB(RspResultB), .RspError(RspError), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] alu_a(input logic [4:0] i, input logic [7:0] a, input logic [7:0] b);
        if (i == DIV) return (b == 8'd0) ? 8'hff : a / b;
        return a + b;
    endfunction

    function automatic logic [7:0] alu_b(input logic [4:0] i, input logic [7:0] a, input logic [7:0] b);
        if (i == DIV) return (b == 8'd0) ? 8'hff : a % b;
        return a ^ b;
    endfunction

    assign AluResultA = alu_a(AluInstruction, AluInputA, AluInputB);
    assign AluResultB = alu_b(AluInstruction, AluInputA, AluInputB);

    always @(posedge Clk) begin
        if (AluInstruction == DIV && !RspValid) div_cnt <= div_cnt + 1;
        else div_cnt <= 0;
    end

    assign AluReady = (div_rdy_en && AluInstruction == DIV && !RspValid && div_cnt >= div_dly)
                   || (ready_noise && AluInstruction != DIV);

    // Expected cycle (relative to acceptance cycle C0) at which RspValid first shows.
    function automatic int exp_latency(input logic [4:0] i, input int unsigned dly, input logic en);
        int cap;
        if (i != DIV) return FIXED + 1;
        if (!en) return TMO + 1;
        cap = (dly + 1 < 2) ? 2 : int'(dly) + 1;
        return (cap <= TMO) ? cap + 1 : TMO + 1;
    endfunction

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset;
        ResetN = 1'b0;
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        RspReady = 1'b0;
        repeat (2) step;
        ResetN = 1'b1;
        model_last = 1'b1;
        step;
    endtask

    task automatic do_op(input logic v0, input logic v1, input logic hold,
                         input op_t op0, input op_t op1, input int unsigned stall,
                         output obs_t o);
        op_t cur;
        logic [7:0] sa, sb;
        logic sid, serr;
        o = '{granted: -1, lat: 0, id: 0, ra: 0, rb: 0, err: 0, alu_bad: 0, grant_bad: 0,
              rsp_unstable: 0, after_busy: 0, after_valid: 0, idle_alu_bad: 0, timed_out: 0};
        Req0Valid = v0; Req0Instruction = op0.instr; Req0InputA = op0.a; Req0InputB = op0.b;
        Req1Valid = v1; Req1Instruction = op1.instr; Req1InputA = op1.a; Req1InputB = op1.b;
        RspReady = 1'b0;
        #1;
        for (int w = 0; w < 6 && o.granted < 0; w++) begin
            if (Req0Ready && Req1Ready) o.grant_bad++;
            if (Req0Ready) o.granted = 0;
            else if (Req1Ready) o.granted = 1;
            else step;
        end
        if (o.granted < 0) begin
            o.timed_out = 1;
            Req0Valid = 1'b0; Req1Valid = 1'b0;
            return;
        end
        cur = (o.granted == 0) ? op0 : op1;
        step;
        if (!hold) begin
            if (o.granted == 0) Req0Valid = 1'b0; else Req1Valid = 1'b0;
        end
        o.lat = 1;
        while (!RspValid && o.lat < 100) begin
            RspReady = 1'($urandom_range(0, 1));
            if (AluInstruction !== cur.instr || AluInputA !== cur.a || AluInputB !== cur.b || Busy !== 1'b1)
                o.alu_bad++;
            if (Req0Ready || Req1Ready) o.grant_bad++;
            step;
            o.lat++;
        end
        RspReady = 1'b0;
        if (!RspValid) begin
            o.timed_out = 1;
            Req0Valid = 1'b0; Req1Valid = 1'b0;
            return;
        end
        o.id = RspId; o.ra = RspResultA; o.rb = RspResultB; o.err = RspError;
        sid = RspId; sa = RspResultA; sb = RspResultB; serr = RspError;
        for (int s = 0; s <= int'(stall); s++) begin
            if (s == int'(stall)) begin
                RspReady = 1'b1;
                #1;
            end
            if (!RspValid || RspId !== sid || RspResultA !== sa || RspResultB !== sb || RspError !== serr)
                o.rsp_unstable++;
            if (AluInstruction !== cur.instr || AluInputA !== cur.a || AluInputB !== cur.b || Busy !== 1'b1)
                o.alu_bad++;
            if (Req0Ready || Req1Ready) o.grant_bad++;
            step;
        end
        RspReady = 1'b0;
        o.after_busy = Busy;
        o.after_valid = RspValid;
        if (AluInstruction !== NOP || AluInputA !== 8'd0 || AluInputB !== 8'd0) o.idle_alu_bad++;
        if (!hold) begin
            Req0Valid = 1'b0;
            Req1Valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        ResetN = 1'b0;
        Req0Valid = 1'b1; Req1Valid = 1'b1;
        Req0Instruction = ADD; Req0InputA = 8'd1; Req0InputB = 8'd2;
        Req1Instruction = ADD; Req1InputA = 8'd3; Req1InputB = 8'd4;
        RspReady = 1'b1;
        repeat (2) step;
        n_tests++;
        if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b%b expected 00", Req0Ready, Req1Ready);
        end
        n_tests++;
        if (Busy !== 1'b0 || RspValid !== 1'b0 || RspError !== 1'b0 || RspId !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got busy=%b valid=%b err=%b id=%b expected 0", Busy, RspValid, RspError, RspId);
        end
        n_tests++;
        if (AluInstruction !== NOP || AluInputA !== 8'd0 || AluInputB !== 8'd0 || RspResultA !== 8'd0 || RspResultB !== 8'd0) begin
            n_fail++; $display("FAIL reset_data: got alu=%h/%h/%h rsp=%h/%h expected 0", AluInstruction, AluInputA, AluInputB, RspResultA, RspResultB);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0; RspReady = 1'b0;
        #2 ResetN = 1'b1;
        step;
    endtask

    task automatic test_add;
        obs_t o;
        op_t p0, p1;
        p0 = '{instr: ADD, a: 8'd5, b: 8'd3};
        p1 = '{instr: NOP, a: 8'd0, b: 8'd0};
        div_rdy_en = 1'b1; ready_noise = 1'b0;
        do_op(1'b1, 1'b0, 1'b0, p0, p1, 0, o);
        model_last = 1'b0;
        n_tests++;
        if (o.granted != 0 || o.timed_out != 0) begin
            n_fail++; $display("FAIL add_grant: got %0d (timeout %0d) expected 0", o.granted, o.timed_out);
        end
        n_tests++;
        if (o.lat != 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", o.lat); end
        n_tests++;
        if (o.id !== 1'b0 || o.ra !== 8'd8 || o.err !== 1'b0) begin
            n_fail++; $display("FAIL add_rsp: got id=%b a=%0d err=%b expected id=0 a=8 err=0", o.id, o.ra, o.err);
        end
        n_tests++;
        if (o.alu_bad != 0 || o.after_busy !== 1'b0 || o.after_valid !== 1'b0 || o.idle_alu_bad != 0) begin
            n_fail++; $display("FAIL add_flow: got alu_bad=%0d busy=%b valid=%b idle_alu_bad=%0d expected 0",
                               o.alu_bad, o.after_busy, o.after_valid, o.idle_alu_bad);
        end
    endtask

    task automatic test_round_robin;
        obs_t o;
        op_t p0, p1;
        int exp_g [3] = '{0, 1, 0};
        apply_reset;
        p0 = '{instr: ADD, a: 8'd10, b: 8'd20};
        p1 = '{instr: 5'b00011, a: 8'd7, b: 8'd9};
        ready_noise = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_op(1'b1, 1'b1, 1'b1, p0, p1, 0, o);
            n_tests++;
            if (o.granted != exp_g[k] || o.grant_bad != 0) begin
                n_fail++; $display("FAIL rr_grant%0d: got %0d (bad %0d) expected %0d", k, o.granted, o.grant_bad, exp_g[k]);
            end
            n_tests++;
            if (o.ra !== ((exp_g[k] == 0) ? 8'd30 : 8'd16) || o.lat != 3) begin
                n_fail++; $display("FAIL rr_rsp%0d: got a=%0d lat=%0d expected a=%0d lat=3",
                                   k, o.ra, o.lat, (exp_g[k] == 0) ? 30 : 16);
            end
        end
        model_last = 1'b0;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        // the held request may have been re-accepted on the final IDLE cycle
        apply_reset;
    endtask

    task automatic test_div;
        obs_t o;
        op_t p0, p1;
        p0 = '{instr: NOP, a: 8'd0, b: 8'd0};
        p1 = '{instr: DIV, a: 8'd17, b: 8'd5};
        div_dly = 9; div_rdy_en = 1'b1; ready_noise = 1'b0;
        do_op(1'b0, 1'b1, 1'b0, p0, p1, 1, o);
        model_last = 1'b1;
        n_tests++;
        if (o.lat != 11) begin n_fail++; $display("FAIL div_latency: got %0d expected 11", o.lat); end
        n_tests++;
        if (o.id !== 1'b1 || o.ra !== 8'd3 || o.rb !== 8'd2 || o.err !== 1'b0) begin
            n_fail++; $display("FAIL div_rsp: got id=%b a=%0d b=%0d err=%b expected 1/3/2/0", o.id, o.ra, o.rb, o.err);
        end
        n_tests++;
        if (o.alu_bad != 0) begin n_fail++; $display("FAIL div_alu_stable: got %0d bad cycles expected 0", o.alu_bad); end
    endtask

    task automatic test_div_timeout;
        obs_t o;
        op_t p0, p1;
        p0 = '{instr: DIV, a: 8'd200, b: 8'd7};
        p1 = p0;
        div_rdy_en = 1'b0; ready_noise = 1'b0;
        do_op(1'b1, 1'b0, 1'b0, p0, p1, 0, o);
        model_last = 1'b0;
        n_tests++;
        if (o.lat != TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", o.lat, TMO + 1); end
        n_tests++;
        if (o.err !== 1'b1 || o.ra !== 8'd0 || o.rb !== 8'd0 || o.id !== 1'b0) begin
            n_fail++; $display("FAIL tmo_rsp: got err=%b a=%0d b=%0d id=%b expected 1/0/0/0", o.err, o.ra, o.rb, o.id);
        end
        div_rdy_en = 1'b1;
    endtask

    task automatic test_resp_stall;
        obs_t o;
        op_t p0, p1;
        p0 = '{instr: 5'b10110, a: 8'd99, b: 8'd1};
        p1 = '{instr: ADD, a: 8'd4, b: 8'd4};
        ready_noise = 1'b1;
        do_op(1'b1, 1'b1, 1'b0, p0, p1, 5, o);
        ready_noise = 1'b0;
        n_tests++;
        if (o.granted != 1) begin n_fail++; $display("FAIL stall_grant: got %0d expected 1", o.granted); end
        model_last = 1'b1;
        n_tests++;
        if (o.rsp_unstable != 0 || o.grant_bad != 0) begin
            n_fail++; $display("FAIL stall_stable: got unstable=%0d grant_bad=%0d expected 0", o.rsp_unstable, o.grant_bad);
        end
        n_tests++;
        if (o.ra !== 8'd8 || o.rb !== 8'd0 || o.lat != 3) begin
            n_fail++; $display("FAIL stall_rsp: got a=%0d b=%0d lat=%0d expected 8/0/3", o.ra, o.rb, o.lat);
        end
    endtask

    task automatic test_reset_mid_exec;
        obs_t o;
        op_t p0, p1;
        int seen;
        div_rdy_en = 1'b0;
        Req0Valid = 1'b1; Req0Instruction = DIV; Req0InputA = 8'd50; Req0InputB = 8'd5;
        Req1Valid = 1'b0;
        #1;
        n_tests++;
        if (Req0Ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept: got %b expected 1", Req0Ready); end
        step;
        repeat (3) step;
        Req0Valid = 1'b1;
        #2 ResetN = 1'b0;
        #1;
        n_tests++;
        if (Busy !== 1'b0 || RspValid !== 1'b0 || AluInstruction !== NOP || AluInputA !== 8'd0 || Req0Ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b valid=%b alu=%h a=%h rdy=%b expected 0/0/00/00/0",
                               Busy, RspValid, AluInstruction, AluInputA, Req0Ready);
        end
        Req0Valid = 1'b0;
        #3 ResetN = 1'b1;
        model_last = 1'b1;
        div_rdy_en = 1'b1;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            step;
            if (RspValid || Busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d active cycles expected 0", seen); end
        p0 = '{instr: ADD, a: 8'd1, b: 8'd1};
        p1 = '{instr: ADD, a: 8'd2, b: 8'd2};
        do_op(1'b1, 1'b1, 1'b0, p0, p1, 0, o);
        n_tests++;
        if (o.granted != 0) begin n_fail++; $display("FAIL mid_first_tie: got %0d expected 0", o.granted); end
        model_last = 1'b0;
    endtask

    task automatic test_random;
        obs_t o;
        op_t p0, p1, cur;
        logic v0, v1;
        int eg, el;
        int unsigned stall;
        for (int it = 0; it < 30; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            p0.instr = ($urandom_range(0, 2) == 0) ? DIV : 5'($urandom);
            p0.a = 8'($urandom); p0.b = 8'($urandom);
            p1.instr = ($urandom_range(0, 2) == 0) ? DIV : 5'($urandom);
            p1.a = 8'($urandom); p1.b = 8'($urandom);
            div_dly = ($urandom_range(0, 9) == 0) ? 80 : $urandom_range(0, 12);
            div_rdy_en = ($urandom_range(0, 7) != 0);
            ready_noise = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            eg = (v0 && v1) ? (model_last ? 0 : 1) : (v1 ? 1 : 0);
            cur = (eg == 0) ? p0 : p1;
            el = exp_latency(cur.instr, div_dly, div_rdy_en);
            do_op(v0, v1, 1'b0, p0, p1, stall, o);
            model_last = (eg == 1);
            n_tests++;
            if (o.granted != eg || o.grant_bad != 0) begin
                n_fail++; $display("FAIL rnd%0d_grant: got %0d (bad %0d) expected %0d", it, o.granted, o.grant_bad, eg);
            end
            n_tests++;
            if (o.lat != el) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, o.lat, el); end
            n_tests++;
            if (el == TMO + 1 && cur.instr == DIV) begin
                if (o.err !== 1'b1 || o.ra !== 8'd0 || o.rb !== 8'd0 || o.id !== 1'(eg)) begin
                    n_fail++; $display("FAIL rnd%0d_tmo: got err=%b a=%h b=%h id=%b expected 1/00/00/%0d", it, o.err, o.ra, o.rb, o.id, eg);
                end
            end else if (o.err !== 1'b0 || o.ra !== alu_a(cur.instr, cur.a, cur.b)
                         || o.rb !== alu_b(cur.instr, cur.a, cur.b) || o.id !== 1'(eg)) begin
                n_fail++; $display("FAIL rnd%0d_rsp: got err=%b a=%h b=%h id=%b expected 0/%h/%h/%0d", it, o.err, o.ra, o.rb, o.id,
                                   alu_a(cur.instr, cur.a, cur.b), alu_b(cur.instr, cur.a, cur.b), eg);
            end
            n_tests++;
            if (o.alu_bad != 0 || o.rsp_unstable != 0 || o.after_busy !== 1'b0 || o.idle_alu_bad != 0) begin
                n_fail++; $display("FAIL rnd%0d_flow: got alu_bad=%0d unstable=%0d busy=%b idle_alu_bad=%0d expected 0",
                                   it, o.alu_bad, o.rsp_unstable, o.after_busy, o.idle_alu_bad);
            end
        end
        div_rdy_en = 1'b1;
        ready_noise = 1'b0;
    endtask

    initial begin
        ResetN = 1'b0;
        Req0Valid = 1'b0; Req1Valid = 1'b0; RspReady = 1'b0;
        Req0Instruction = NOP; Req0InputA = '0; Req0InputB = '0;
        Req1Instruction = NOP; Req1InputA = '0; Req1InputB = '0;
        test_reset;
        test_add;
        test_round_robin;
        test_div;
        test_div_timeout;
        test_resp_stall;
        test_reset_mid_exec;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
